// File: rtl/counter_defs_pkg.sv
// Shared definitions for the modulo-N time-digit counter family:
// auto-repeat FSM states, step directions and default repeat timing.
package counter_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam int unsigned DEF_REPEAT_DELAY  = 500;
  localparam int unsigned DEF_REPEAT_PERIOD = 100;

endpackage

// File: rtl/counter_mod_set_auto_repeat.sv
// Hold-to-auto-repeat button handler: one step on press, another after
// REPEAT_DELAY cycles of holding, then one every REPEAT_PERIOD cycles.
module auto_repeat
  import counter_defs::*;
#(
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned TIMER_W       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic inc_btn,
  input  logic dec_btn,
  output logic step,
  output dir_t dir
);

  localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD - 1);

  rep_state_t         state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  dir_t               dir_q, dir_n;
  logic               press_inc, press_dec, held;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      dir_q <= DIR_UP;
    end else begin
      state <= state_n;
      timer <= timer_n;
      dir_q <= dir_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    dir_n     = dir_q;
    step      = 1'b0;
    dir       = dir_q;
    press_inc = inc_btn & ~dec_btn;
    press_dec = dec_btn & ~inc_btn;
    held      = (dir_q == DIR_UP) ? press_inc : press_dec;

    if (!enable) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press_inc || press_dec) begin
            // Direction is decided here and latched for the rest of the hold.
            dir_n   = press_dec ? DIR_DN : DIR_UP;
            dir     = dir_n;
            step    = 1'b1;
            timer_n = DELAY_LOAD;
            state_n = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!held) begin
            state_n = IDLE;
            timer_n = '0;
          end else if (timer == '0) begin
            step    = 1'b1;
            timer_n = PERIOD_LOAD;
            state_n = REPEAT;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_mod_set.sv
// Modulo-N time-digit counter with set mode (inc/dec auto-repeat) and BCD outputs.
// Optional COUNTER_LOAD_EN adds a clamped parallel load (load/load_val).
module counter_mod_set
  import counter_defs::*;
#(
  parameter int unsigned MODULUS       = 60,
  parameter int unsigned WIDTH         = 7,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned TIMER_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             set_mode,
  input  logic             inc_btn,
  input  logic             dec_btn,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic             zC
`ifdef COUNTER_LOAD_EN
  ,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic rep_en;
  logic step;
  dir_t dir;
  logic [7:0] count8;

`ifdef COUNTER_LOAD_EN
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
  // A load also pulls the repeat FSM back to IDLE on the same edge.
  assign rep_en = set_mode & ~load;
`else
  assign rep_en = set_mode;
`endif

  auto_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .TIMER_W      (TIMER_W)
  ) u_auto_repeat (
    .clk    (clk),
    .reset  (reset),
    .enable (rep_en),
    .inc_btn(inc_btn),
    .dec_btn(dec_btn),
    .step   (step),
    .dir    (dir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      zC    <= 1'b0;
    end else begin
      zC <= 1'b0;
`ifdef COUNTER_LOAD_EN
      if (load) begin
        count <= ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
      end else
`endif
      if (set_mode) begin
        if (step) begin
          if (dir == DIR_UP) count <= (count == MAX_VAL) ? '0 : count + 1'b1;
          else               count <= (count == '0) ? MAX_VAL : count - 1'b1;
        end
      end else if (tick_in) begin
        if (count == MAX_VAL) begin
          count <= '0;
          zC    <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // Count never exceeds 99, so an 8-bit view is enough for the digit split.
  always_comb begin
    count8 = 8'(count);
    ones   = 4'(count8 % 8'd10);
    tens   = 4'(count8 / 8'd10);
  end

endmodule

// File: tb/tb_counter_mod_set.sv
// Self-checking bench for counter_mod_set: vector table plus directed
// sequences for auto-repeat, mode switches, async reset and cascading.
module tb_counter_mod_set;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in, set_mode, inc_btn, dec_btn;
  logic [6:0] count, min_count;
  logic [4:0] hr_count;
  logic [3:0] ones, tens, min_ones, min_tens, hr_ones, hr_tens;
  logic       zC, min_zC, hr_zC;
  logic       load;
  logic [6:0] load_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_mod_set #(
    .MODULUS(60), .WIDTH(7), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .TIMER_W(16)
  ) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .set_mode(set_mode),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .count(count), .ones(ones),
    .tens(tens), .zC(zC)
`ifdef COUNTER_LOAD_EN
    , .load(load), .load_val(load_val)
`endif
  );

  counter_mod_set #(
    .MODULUS(60), .WIDTH(7), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .TIMER_W(16)
  ) u_min (
    .clk(clk), .reset(reset), .tick_in(zC), .set_mode(1'b0),
    .inc_btn(1'b0), .dec_btn(1'b0), .count(min_count), .ones(min_ones),
    .tens(min_tens), .zC(min_zC)
`ifdef COUNTER_LOAD_EN
    , .load(1'b0), .load_val(7'd0)
`endif
  );

  counter_mod_set #(
    .MODULUS(24), .WIDTH(5), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .TIMER_W(16)
  ) u_hr (
    .clk(clk), .reset(reset), .tick_in(min_zC), .set_mode(1'b0),
    .inc_btn(1'b0), .dec_btn(1'b0), .count(hr_count), .ones(hr_ones),
    .tens(hr_tens), .zC(hr_zC)
`ifdef COUNTER_LOAD_EN
    , .load(1'b0), .load_val(5'd0)
`endif
  );

  typedef struct {
    logic  tick, sm, inc, dec;
    int    cnt;
    logic  zc;
    int    o, t;
    string name;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic t, input logic s, input logic i, input logic d);
    tick_in  = t;
    set_mode = s;
    inc_btn  = i;
    dec_btn  = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    load = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int hr_changes;
    logic [4:0] hr_prev;
    int exp_hold[10];

    vecs[0]  = '{1, 0, 0, 0, 1,  0, 1, 0, "run_tick_1"};
    vecs[1]  = '{1, 0, 0, 0, 2,  0, 2, 0, "run_tick_2"};
    vecs[2]  = '{0, 0, 0, 0, 2,  0, 2, 0, "run_idle"};
    vecs[3]  = '{1, 1, 0, 0, 2,  0, 2, 0, "set_tick_dropped"};
    vecs[4]  = '{0, 1, 1, 0, 3,  0, 3, 0, "set_inc_tap"};
    vecs[5]  = '{0, 1, 0, 0, 3,  0, 3, 0, "set_release"};
    vecs[6]  = '{0, 1, 0, 1, 2,  0, 2, 0, "set_dec_tap"};
    vecs[7]  = '{0, 1, 1, 1, 2,  0, 2, 0, "set_both_btn"};
    vecs[8]  = '{0, 1, 0, 1, 1,  0, 1, 0, "set_dec_after_both"};
    vecs[9]  = '{0, 1, 0, 0, 1,  0, 1, 0, "set_release_2"};
    vecs[10] = '{0, 1, 0, 1, 0,  0, 0, 0, "set_dec_to_0"};
    vecs[11] = '{0, 1, 0, 0, 0,  0, 0, 0, "set_release_3"};
    vecs[12] = '{0, 1, 0, 1, 59, 0, 9, 5, "set_dec_wrap"};
    vecs[13] = '{0, 1, 0, 0, 59, 0, 9, 5, "set_release_4"};
    vecs[14] = '{1, 0, 0, 0, 0,  1, 0, 0, "run_wrap_zc"};
    vecs[15] = '{0, 0, 0, 0, 0,  0, 0, 0, "run_zc_clears"};
    vecs[16] = '{1, 0, 0, 0, 1,  0, 1, 0, "run_after_wrap"};
    exp_hold = '{11, 11, 11, 11, 12, 12, 13, 13, 14, 14};

    load_val = '0;
    reset    = 1'b1;
    load     = 1'b0;
    drive(0, 0, 0, 0);
    cycle();
    cycle();
    check("reset_count", int'(count), 0);
    check("reset_zc", int'(zC), 0);
    check("reset_ones", int'(ones), 0);
    check("reset_tens", int'(tens), 0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].tick, vecs[k].sm, vecs[k].inc, vecs[k].dec);
      cycle();
      check({vecs[k].name, "_count"}, int'(count), vecs[k].cnt);
      check({vecs[k].name, "_zc"}, int'(zC), int'(vecs[k].zc));
      check({vecs[k].name, "_ones"}, int'(ones), vecs[k].o);
      check({vecs[k].name, "_tens"}, int'(tens), vecs[k].t);
    end

    // Auto-repeat from count 10 with delay 4 / period 2.
    do_reset();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
    check("preset_10", int'(count), 10);
    drive(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check($sformatf("hold_inc_c%0d", i), int'(count), exp_hold[i]);
    end
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("release_no_step", int'(count), 14);
    drive(0, 1, 1, 0);
    cycle();
    check("fresh_press_from_idle", int'(count), 15);
    cycle();
    check("delay_no_step", int'(count), 15);
    drive(1, 0, 1, 0);
    cycle();
    check("drop_set_tick_resumes", int'(count), 16);
    drive(0, 1, 1, 0);
    cycle();
    check("reenter_set_fresh_step", int'(count), 17);
    for (int i = 0; i < 5; i++) cycle();
    check("into_repeat", int'(count), 18);
    #2 reset = 1'b1;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_zc", int'(zC), 0);
    cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0);

    // Async reset must clear a live zC pulse.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 60; i++) cycle();
    check("wrap60_count", int'(count), 0);
    check("wrap60_zc", int'(zC), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_zc_live", int'(zC), 0);
    cycle();

    // Cascade sec -> min -> hr over one hour of ticks.
    reset = 1'b0;
    drive(1, 0, 0, 0);
    hr_changes = 0;
    hr_prev    = hr_count;
    for (int i = 0; i < 3600; i++) begin
      cycle();
      if (i == 36) begin
        check("bcd37_ones", int'(ones), 7);
        check("bcd37_tens", int'(tens), 3);
      end
      if (hr_count != hr_prev) hr_changes++;
      hr_prev = hr_count;
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (hr_count != hr_prev) hr_changes++;
      hr_prev = hr_count;
    end
    check("cascade_sec", int'(count), 0);
    check("cascade_min", int'(min_count), 0);
    check("cascade_hr", int'(hr_count), 1);
    check("cascade_hr_changes", hr_changes, 1);

`ifdef COUNTER_LOAD_EN
    do_reset();
    load = 1'b1; load_val = 7'd75;
    cycle();
    check("load_clamp", int'(count), 59);
    load_val = 7'd58;
    drive(1, 0, 0, 0);
    cycle();
    check("load_beats_tick", int'(count), 58);
    load = 1'b0;
    cycle();
    check("load_wrap_59", int'(count), 59);
    cycle();
    check("load_wrap_0", int'(count), 0);
    check("load_wrap_zc", int'(zC), 1);
    cycle();
    check("load_wrap_1", int'(count), 1);
    check("load_wrap_zc_low", int'(zC), 0);
    drive(0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
